multicycle_control_fsm: RTL

- Multi-cycle RV32I main control unit: a sequential FSM driving the datapath through IF/ID/EX/MEM/WB and HALT.
- It is the producer of `alu_ctrl_op[1:0]`, which the ALU control unit decodes into `alu_op`.
- Consumes the IR opcode, the branch condition from the ALU, the memory ready handshake and the ECALL halt request.
- Sequences PC, IR, memory, register-file and ALU-operand control.

---
 rtl/multicycle_control_fsm_pkg.sv | 42 ++++
 rtl/multicycle_control_fsm_control_output_decode.sv | 110 +++++++++++
 rtl/multicycle_control_fsm.sv | 83 ++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I main control unit: states, opcodes,
// ALU control selectors, operand-B selectors and write-back selectors.
package multicycle_control_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALU_CTRL_ADD    = 2'b00;
  localparam logic [1:0] ALU_CTRL_BRANCH = 2'b01;
  localparam logic [1:0] ALU_CTRL_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_CTRL_JUMP   = 2'b11;

  localparam logic [1:0] ALU_SRC_B_REG  = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM  = 2'b10;

  localparam logic [1:0] WB_SEL_ALUOUT = 2'b00;
  localparam logic [1:0] WB_SEL_MDR    = 2'b01;
  localparam logic [1:0] WB_SEL_PC     = 2'b10;

  // Opcodes that take the EX path; ECALL is handled separately in ID.
  function automatic logic is_exec_opcode(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_control_output_decode.sv
// Combinational datapath control decode from current state, opcode and the
// same-cycle memory/branch handshakes; everything is forced low while in reset.
module control_output_decode
  import multicycle_control_fsm_pkg::*;
(
  input  logic       reset_n,
  input  state_t     state,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       alu_bcond,
  output logic       pc_write,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_ctrl_op,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       is_halted
);

  always_comb begin
    pc_write    = 1'b0;
    pc_source   = 1'b0;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = ALU_SRC_B_REG;
    alu_ctrl_op = ALU_CTRL_ADD;
    reg_write   = 1'b0;
    wb_sel      = WB_SEL_ALUOUT;
    is_halted   = 1'b0;

    // Reset gates even the IF fetch request so no memory access leaks out.
    if (reset_n) begin
      case (state)
        ST_IF: begin
          mem_read  = 1'b1;
          alu_src_b = ALU_SRC_B_FOUR;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        ST_ID: alu_src_b = ALU_SRC_B_IMM;
        ST_EX: begin
          case (opcode)
            OP_R: begin
              alu_src_a   = 1'b1;
              alu_ctrl_op = ALU_CTRL_FUNCT;
            end
            OP_I: begin
              alu_src_a   = 1'b1;
              alu_src_b   = ALU_SRC_B_IMM;
              alu_ctrl_op = ALU_CTRL_FUNCT;
            end
            OP_LOAD, OP_STORE: begin
              alu_src_a = 1'b1;
              alu_src_b = ALU_SRC_B_IMM;
            end
            OP_BRANCH: begin
              alu_src_a   = 1'b1;
              alu_ctrl_op = ALU_CTRL_BRANCH;
              pc_write    = alu_bcond;
              pc_source   = alu_bcond;
            end
            // Link register takes the already-incremented PC on the same edge PC reloads.
            OP_JAL: begin
              alu_ctrl_op = ALU_CTRL_JUMP;
              reg_write   = 1'b1;
              wb_sel      = WB_SEL_PC;
              pc_write    = 1'b1;
              pc_source   = 1'b1;
            end
            OP_JALR: begin
              alu_src_a   = 1'b1;
              alu_src_b   = ALU_SRC_B_IMM;
              alu_ctrl_op = ALU_CTRL_JUMP;
              reg_write   = 1'b1;
              wb_sel      = WB_SEL_PC;
              pc_write    = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          if (opcode == OP_LOAD) begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
          end else if (opcode == OP_STORE) begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
          end
        end
        ST_WB: begin
          reg_write = 1'b1;
          wb_sel    = (opcode == OP_LOAD) ? WB_SEL_MDR : WB_SEL_ALUOUT;
        end
        ST_HALT: is_halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I main control FSM: holds the state register and next-state
// logic; datapath controls come from control_output_decode.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter logic HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  input  logic       mem_ready,
  input  logic       halt_req,
  output logic       pc_write,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_ctrl_op,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       is_halted
);

  state_t state, next_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IF;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IF: if (mem_ready) next_state = ST_ID;
      ST_ID: begin
        if (opcode == OP_SYSTEM)          next_state = halt_req ? ST_HALT : ST_IF;
        else if (is_exec_opcode(opcode))  next_state = ST_EX;
        else                              next_state = HALT_ON_ILLEGAL ? ST_HALT : ST_IF;
      end
      ST_EX: begin
        case (opcode)
          OP_R, OP_I:         next_state = ST_WB;
          OP_LOAD, OP_STORE:  next_state = ST_MEM;
          default:            next_state = ST_IF;
        endcase
      end
      // Memory stalls keep us here with the request held steady.
      ST_MEM: begin
        if (opcode == OP_LOAD)       next_state = mem_ready ? ST_WB : ST_MEM;
        else if (opcode == OP_STORE) next_state = mem_ready ? ST_IF : ST_MEM;
        else                         next_state = ST_IF;
      end
      ST_WB:   next_state = ST_IF;
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_IF;
    endcase
  end

  control_output_decode u_decode (
    .reset_n     (reset_n),
    .state       (state),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .alu_bcond   (alu_bcond),
    .pc_write    (pc_write),
    .pc_source   (pc_source),
    .i_or_d      (i_or_d),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_ctrl_op (alu_ctrl_op),
    .reg_write   (reg_write),
    .wb_sel      (wb_sel),
    .is_halted   (is_halted)
  );

endmodule
